// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with a direct-mapped one-word-line instruction cache
module inst_fetch #(
    parameter int          ICACHE_IDX_W = 6,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst,
    output logic        oID_valid,
    output logic [31:0] oID_inst,
    output logic [31:0] oID_pc,
    input  logic        iID_ready,
    input  logic        iJP_en,
    input  logic [31:0] iJP_pc
);

    localparam int LINES = 1 << ICACHE_IDX_W;
    localparam int TAG_W = 30 - ICACHE_IDX_W;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_MISS  = 2'd1;
    localparam logic [1:0] ST_ABORT = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic              mc_en_q, mc_en_d;
    logic [31:0]       mc_addr_q, mc_addr_d;
    logic              id_valid_q, id_valid_d;
    logic [31:0]       id_inst_q, id_inst_d;
    logic [31:0]       id_pc_q, id_pc_d;
    logic [LINES-1:0]  line_valid_q, line_valid_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [ICACHE_IDX_W-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0]        pc_tag, fill_tag;
    logic                    hit, slot_free, drain, fill_en;
    logic [31:0]             jp_target;

    assign pc_idx    = pc_q[ICACHE_IDX_W+1:2];
    assign pc_tag    = pc_q[31:ICACHE_IDX_W+2];
    // A fill always targets the outstanding request address, not the current pc.
    assign fill_idx  = mc_addr_q[ICACHE_IDX_W+1:2];
    assign fill_tag  = mc_addr_q[31:ICACHE_IDX_W+2];
    assign hit       = line_valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign slot_free = !id_valid_q || iID_ready;
    assign drain     = id_valid_q && iID_ready;
    assign jp_target = iJP_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mc_en_d      = mc_en_q;
        mc_addr_d    = mc_addr_q;
        id_valid_d   = id_valid_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        line_valid_d = line_valid_q;
        fill_en      = 1'b0;
        if (rdy) begin
            case (state_q)
                ST_FETCH: begin
                    if (!iJP_en) begin
                        if (hit) begin
                            if (slot_free) begin
                                id_inst_d  = data_mem[pc_idx];
                                id_pc_d    = pc_q;
                                id_valid_d = 1'b1;
                                pc_d       = pc_q + 32'd4;
                            end
                        end else begin
                            state_d   = ST_MISS;
                            mc_en_d   = 1'b1;
                            mc_addr_d = pc_q;
                            if (drain) id_valid_d = 1'b0;
                        end
                    end
                end
                ST_MISS: begin
                    if (drain) id_valid_d = 1'b0;
                    if (iMC_done) begin
                        fill_en = 1'b1;
                        mc_en_d = 1'b0;
                        state_d = ST_FETCH;
                    end else if (iJP_en) begin
                        // Drop the request for a cycle so the controller restarts cleanly.
                        mc_en_d = 1'b0;
                        state_d = ST_ABORT;
                    end
                end
                ST_ABORT: begin
                    if (drain) id_valid_d = 1'b0;
                    state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
            if (fill_en) line_valid_d[fill_idx] = 1'b1;
            if (iJP_en) begin
                pc_d       = jp_target;
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            mc_en_q      <= 1'b0;
            mc_addr_q    <= 32'h0;
            id_valid_q   <= 1'b0;
            id_inst_q    <= 32'h0;
            id_pc_q      <= 32'h0;
            line_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mc_en_q      <= mc_en_d;
            mc_addr_q    <= mc_addr_d;
            id_valid_q   <= id_valid_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            line_valid_q <= line_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iMC_inst;
        end
    end

    assign oMC_en    = mc_en_q;
    assign oMC_addr  = mc_addr_q;
    assign oID_valid = id_valid_q;
    assign oID_inst  = id_inst_q;
    assign oID_pc    = id_pc_q;

endmodule
